vedic_mul_seq: RTL and testbench
================================

Name: vedic_mul_seq

Overview:
Parametrised, sequential successor to the team's fixed 4x4 combinational Vedic multiplier. Multiplies two WIDTH-bit operands with the Urdhva-Tiryakbhyam column method: operands are split into DIGIT-bit digits, and one product column is accumulated per clock. Optional signed mode is selected per operation. Valid/ready handshakes sit on both sides, so the block slots behind the tt_um top-level pin wrapper or any internal datapath.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of DIGIT and at least 2*DIGIT
DIGIT, 2, digit width in bits; each digit product is a DIGIT x DIGIT multiply
(derived) N = WIDTH/DIGIT digits; NCOL = 2N-1 product columns

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes all registers
in_valid  input  1  operands on in_a/in_b/in_signed are valid
in_ready  output  1  block can accept an operation
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
in_signed  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  out_p holds a completed product
out_ready  input  1  consumer accepts out_p
out_p  output  2*WIDTH  product

Behaviour:
- Reset (asynchronous, rst_n=0, any state):
  - state=IDLE; out_valid=0; out_p=0; accumulator, column counter and operand registers cleared.
  - An operation in progress is discarded. No output appears for it after reset is released.
- ena=0: every register holds its value and in_ready=0. out_valid and out_p keep their values. No handshake completes.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = ena.
  - Accept edge: in_valid=1 and ena=1. The block latches the operands, clears the accumulator, sets k=0 and moves to CALC.
- Signed handling, done at accept:
  - If in_signed=1, latch |in_a| and |in_b| as WIDTH-bit unsigned magnitudes. The most negative value maps to 2^(WIDTH-1), which fits.
  - Latch neg = in_a[MSB] ^ in_b[MSB].
  - If in_signed=0, neg=0 and the raw operands are latched.
- CALC (in_ready=0):
  - Each enabled cycle adds column k: acc += (sum over i+j=k of a_i*b_j) << (k*DIGIT), where a_i and b_j are DIGIT-bit digits of the latched magnitudes.
  - Column-sum width is 2*DIGIT + clog2(N). acc is 2*WIDTH bits wide and cannot overflow.
  - k increments each cycle.
  - At k=NCOL-1, the same edge loads out_p = neg ? -(final acc) : final acc (2*WIDTH-bit two's complement), sets out_valid=1 and moves to DONE.
- Latency: out_valid rises NCOL clock edges after the accept edge (7 for 8/2, 3 for 4/2), counting enabled cycles only.
- DONE:
  - in_ready=0. out_valid=1 and out_p are stable until out_ready=1 with ena=1.
  - On that edge, out_valid goes to 0 and state goes to IDLE. out_p keeps its last value.
- Throughput: one operation per NCOL+2 cycles when there is no backpressure.
- in_valid is ignored outside IDLE. Operand changes after acceptance have no effect.
- Zero operand: the product is 0. Signed mode with zero magnitude yields 0, never a negative zero.

Test Plan:
- Unsigned, WIDTH=8: in_a=13, in_b=11, in_signed=0 accepted at edge E → out_p=16'd143 with out_valid=1 after exactly 7 edges; in_ready=0 throughout.
- Unsigned maximum: 255*255 → 16'hFE01. Signed: in_a=8'hFD (-3), in_b=8'h05 → 16'hFFF1.
- Signed boundary: in_a=in_b=8'h80 → 16'h4000. in_a=8'h80, in_b=8'h01 → 16'hFF80. in_a=0, in_b=8'h80 → 16'h0000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_p and out_valid stable and in_ready=0. On out_ready=1, the next cycle shows out_valid=0 and in_ready=1.
- Reset and ena:
  - Assert rst_n=0 at CALC k=3 → outputs go to zero immediately, and no out_valid appears after release.
  - Drop ena for 4 cycles mid-CALC → result is still correct and latency is extended by exactly 4.
- Parameter sweep: WIDTH=4, DIGIT=2, 15*15 → 8'hE1 after 3 edges. WIDTH=16, DIGIT=4 with random unsigned and signed pairs → matches reference a*b, latency 7.

Source files
------------

// File: rtl/vedic_mul_seq_if.sv
// Operand/product handshake bundle for vedic_mul_seq.
// valid/ready: a transfer happens on a rising edge where valid=1, ready=1 and ena=1;
// valid and its payload stay stable until that edge, and ready never waits on valid.
interface vedic_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/vedic_mul_seq.sv
// Sequential Urdhva-Tiryakbhyam multiplier: one DIGIT-wide product column per enabled clock,
// sign handled as magnitude multiply plus final negate.
module vedic_mul_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    vedic_mul_seq_if.slave    bus,
    output logic [1:0]        dbg_state
);

    localparam int N    = WIDTH / DIGIT;
    localparam int NCOL = 2 * N - 1;
    localparam int KW   = $clog2(NCOL);
    localparam int CSW  = 2 * DIGIT + $clog2(N);
    localparam int PW   = 2 * WIDTH;

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2 * DIGIT) begin : g_bad_params
            $error("vedic_mul_seq: WIDTH must be a multiple of DIGIT and at least 2*DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             neg_q;
    logic [KW-1:0]    k_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    p_q;
    logic             out_valid_q;

    logic             ready;
    logic             accept;
    logic             step;
    logic             finish;
    logic             drain;

    logic [2*DIGIT-1:0] pp [N][N];
    logic [CSW-1:0]     col_sum;
    logic [PW-1:0]      acc_next;
    logic [PW-1:0]      result;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        // The most negative value negates to itself, which read unsigned is exactly 2^(WIDTH-1).
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    // Every digit-pair product; the current column picks the pairs whose indices sum to k.
    for (genvar i = 0; i < N; i++) begin : g_pp_row
        for (genvar j = 0; j < N; j++) begin : g_pp_col
            assign pp[i][j] = (2*DIGIT)'(a_q[i*DIGIT +: DIGIT]) * (2*DIGIT)'(b_q[j*DIGIT +: DIGIT]);
        end
    end

    always_comb begin
        col_sum = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i + j == int'(k_q)) begin
                    col_sum = col_sum + CSW'(pp[i][j]);
                end
            end
        end
        acc_next = acc_q + (PW'(col_sum) << (int'(k_q) * DIGIT));
        result   = neg_q ? (~acc_next + PW'(1)) : acc_next;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        drain   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = ena;
                if (ena && bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (ena) begin
                    step = 1'b1;
                    if (k_q == KW'(NCOL - 1)) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (ena && bus.out_ready) begin
                    drain   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            k_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= magnitude(bus.in_a, bus.in_signed);
                b_q   <= magnitude(bus.in_b, bus.in_signed);
                neg_q <= bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
                acc_q <= '0;
                k_q   <= '0;
            end else if (step) begin
                acc_q <= acc_next;
                if (!finish) begin
                    k_q <= k_q + KW'(1);
                end
            end

            if (finish) begin
                p_q         <= result;
                out_valid_q <= 1'b1;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = p_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Bench for vedic_mul_seq at 8/2, 4/2 and 16/4: vector table, corner sequences, random ops.
module tb_vedic_mul_seq;

    logic clk;
    logic rst_n;
    logic ena;
    logic [1:0] dbg8;
    logic [1:0] dbg4;
    logic [1:0] dbg16;

    int n_cmp;
    int n_bad;

    vedic_mul_seq_if #(.WIDTH(8))  bus8 ();
    vedic_mul_seq_if #(.WIDTH(4))  bus4 ();
    vedic_mul_seq_if #(.WIDTH(16)) bus16 ();

    vedic_mul_seq #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus8.slave), .dbg_state(dbg8)
    );
    vedic_mul_seq #(.WIDTH(4), .DIGIT(2)) u4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus4.slave), .dbg_state(dbg4)
    );
    vedic_mul_seq #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus16.slave), .dbg_state(dbg16)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- instance helpers ----------------
    function automatic int width_of(input int inst);
        case (inst)
            0: return 8;
            1: return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int ncol_of(input int inst);
        case (inst)
            0: return 7;
            1: return 3;
            default: return 7;
        endcase
    endfunction

    function automatic logic get_ov(input int inst);
        case (inst)
            0: return bus8.out_valid;
            1: return bus4.out_valid;
            default: return bus16.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int inst);
        case (inst)
            0: return bus8.in_ready;
            1: return bus4.in_ready;
            default: return bus16.in_ready;
        endcase
    endfunction

    function automatic logic [31:0] get_p(input int inst);
        case (inst)
            0: return 32'(bus8.out_p);
            1: return 32'(bus4.out_p);
            default: return 32'(bus16.out_p);
        endcase
    endfunction

    // Reference: plain integer product of the operands read as signed or unsigned numbers.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        longint m;
        longint sa;
        longint sb;
        longint pr;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (s && sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
        if (s && sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        pr = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
        return 32'(pr);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_in(input int inst, input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic s);
        case (inst)
            0: begin bus8.in_valid = v;  bus8.in_a = a[7:0];  bus8.in_b = b[7:0];  bus8.in_signed = s;  end
            1: begin bus4.in_valid = v;  bus4.in_a = a[3:0];  bus4.in_b = b[3:0];  bus4.in_signed = s;  end
            default: begin bus16.in_valid = v; bus16.in_a = a; bus16.in_b = b; bus16.in_signed = s; end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation; lat counts edges from the accept edge to the first out_valid sample.
    // stall_at >= 0 drops ena for 4 edges once that many edges have passed.
    task automatic run_op(input int inst, input logic [15:0] a, input logic [15:0] b, input logic s,
                          input int stall_at, output logic [31:0] p, output int lat,
                          output logic ready_bad);
        int w;
        w = 0;
        lat = 0;
        ready_bad = 1'b0;
        p = '0;
        drive_in(inst, 1'b1, a, b, s);
        while (!get_ir(inst) && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) begin
            check("accept_timeout", 32'(w), 32'(0));
            drive_in(inst, 1'b0, '0, '0, 1'b0);
            lat = -1;
            return;
        end
        @(posedge clk); #1;
        drive_in(inst, 1'b0, ~a, ~b, ~s);
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (get_ov(inst)) break;
            if (get_ir(inst)) ready_bad = 1'b1;
            if (lat == stall_at) begin
                ena = 1'b0;
                repeat (4) begin
                    @(posedge clk); #1;
                    lat++;
                    if (get_ir(inst) || get_ov(inst)) ready_bad = 1'b1;
                end
                ena = 1'b1;
            end
        end
        p = get_p(inst);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          inst;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] p;
        logic [31:0] exp_q[$];
        logic [31:0] exp;
        int          lat;
        logic        rb;
        int          bad_cnt;
        int          inst;
        logic [15:0] ra;
        logic [15:0] rbv;
        logic        rs;

        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{0, 16'd13,     16'd11,     1'b0, 32'd143,        7};
        vecs[1] = '{0, 16'hFF,     16'hFF,     1'b0, 32'hFE01,       7};
        vecs[2] = '{0, 16'hFD,     16'h05,     1'b1, 32'hFFF1,       7};
        vecs[3] = '{0, 16'h80,     16'h80,     1'b1, 32'h4000,       7};
        vecs[4] = '{0, 16'h80,     16'h01,     1'b1, 32'hFF80,       7};
        vecs[5] = '{0, 16'h00,     16'h80,     1'b1, 32'h0000,       7};
        vecs[6] = '{1, 16'hF,      16'hF,      1'b0, 32'hE1,         3};
        vecs[7] = '{1, 16'h8,      16'h8,      1'b1, 32'h40,         3};
        vecs[8] = '{2, 16'hFFFF,   16'hFFFF,   1'b0, 32'hFFFE0001,   7};
        vecs[9] = '{2, 16'h8000,   16'h8000,   1'b1, 32'h40000000,   7};

        ena = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) drive_in(i, 1'b0, '0, '0, 1'b0);
        bus8.out_ready = 1'b1;
        bus4.out_ready = 1'b1;
        bus16.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state8", 32'(dbg8), 32'(0));
        check("reset_ov8", 32'(bus8.out_valid), 32'(0));
        check("reset_p8", get_p(0), 32'(0));
        check("reset_p16", get_p(2), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready8", 32'(bus8.in_ready), 32'(1));

        // table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].s, -1, p, lat, rb);
            check($sformatf("vec%0d_p", i), p, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_ready_low", i), 32'(rb), 32'(0));
        end

        // backpressure: hold the result for 10 cycles
        bus8.out_ready = 1'b0;
        run_op(0, 16'd200, 16'd3, 1'b0, -1, p, lat, rb);
        check("bp_p", p, 32'h258);
        bad_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus8.out_valid !== 1'b1 || get_p(0) !== 32'h258 || bus8.in_ready !== 1'b0) bad_cnt++;
        end
        check("bp_hold_stable", 32'(bad_cnt), 32'(0));
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ov", 32'(bus8.out_valid), 32'(0));
        check("bp_release_ready", 32'(bus8.in_ready), 32'(1));
        check("bp_release_p_kept", get_p(0), 32'h258);

        // reset in the middle of CALC (k=3)
        drive_in(0, 1'b1, 16'd9, 16'd7, 1'b0);
        @(posedge clk); #1;
        drive_in(0, 1'b0, '0, '0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("mid_calc_state", 32'(dbg8), 32'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_ov", 32'(bus8.out_valid), 32'(0));
        check("async_rst_p", get_p(0), 32'(0));
        check("async_rst_state", 32'(dbg8), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus8.out_valid !== 1'b0) bad_cnt++;
        end
        check("no_ov_after_reset", 32'(bad_cnt), 32'(0));
        check("ready_after_reset", 32'(bus8.in_ready), 32'(1));

        // ena dropped for 4 cycles mid-CALC
        run_op(0, 16'd13, 16'd11, 1'b0, 2, p, lat, rb);
        check("stall_p", p, 32'd143);
        check("stall_lat", 32'(lat), 32'(11));
        check("stall_ready_low", 32'(rb), 32'(0));
        run_op(2, 16'hBEEF, 16'h8001, 1'b1, 3, p, lat, rb);
        check("stall16_p", p, ref_mul(16, 16'hBEEF, 16'h8001, 1'b1));
        check("stall16_lat", 32'(lat), 32'(11));

        // randomized operations against the reference model
        for (int r = 0; r < 40; r++) begin
            inst = int'($urandom_range(0, 2));
            ra   = 16'($urandom);
            rbv  = 16'($urandom);
            rs   = 1'($urandom_range(0, 1));
            if (r % 10 == 0) ra = '0;
            ra  = ra  & 16'((32'd1 << width_of(inst)) - 1);
            rbv = rbv & 16'((32'd1 << width_of(inst)) - 1);
            exp_q.push_back(ref_mul(width_of(inst), ra, rbv, rs));
            run_op(inst, ra, rbv, rs, -1, p, lat, rb);
            exp = exp_q.pop_front();
            check($sformatf("rnd%0d_i%0d_%0h_%0h_s%0d", r, inst, ra, rbv, rs), p, exp);
            check($sformatf("rnd%0d_lat", r), 32'(lat), 32'(ncol_of(inst)));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
